regfile_master: RTL and testbench
=================================

# regfile_master

Sequencing initiator for the single-port 32 x 32-bit register file (sel/wr/datain/dataout port). It accepts read and write requests over a valid/ready channel and drives the register-file port for the required hold cycles. It captures read data and returns one response per request. It sits between the datapath/host control and the register file, and is the only agent driving that port.

## Interface
- DATA_W, 32, data width of requests, responses and register-file port
- ADDR_W, 5, register select width
- WR_HOLD, 2, cycles rf_wr/rf_sel/rf_wdata are held for a write (minimum 2)
- RD_WAIT, 2, cycles rf_sel is held before rf_rdata is sampled (minimum 2)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  register select
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (read), read-back data (write, verify build), else 0
- rsp_err  out  1  write read-back mismatch (verify build only)
- rf_sel  out  ADDR_W  register-file select
- rf_wr  out  1  register-file write enable
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file read data
- busy  out  1  state != IDLE
- txn_count  out  16  completed responses, wraps at 0xFFFF -> 0

## Operation
- States: IDLE, WRITE, READ, VERIFY (verify build only), RESP.
- IDLE: req_ready=1. On req_valid&req_ready, register req_addr->rf_sel and req_wdata->rf_wdata/shadow, then go to WRITE (rf_wr<=1) or READ (rf_wr<=0).
- WRITE: hold counter counts WR_HOLD edges. Go to RESP (or VERIFY), with rf_wr<=0 on the same edge.
- READ: hold counter counts RD_WAIT edges. On the final edge rsp_rdata<=rf_rdata, rsp_err<=0, then go to RESP.
- VERIFY: rf_wr=0, rf_sel unchanged, wait RD_WAIT edges. Then rsp_rdata<=rf_rdata and rsp_err<=(rf_rdata!=shadow), then go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are stable until rsp_valid&rsp_ready. On that edge: go to IDLE and increment txn_count.
- req_ready=0 in every non-IDLE state. Requests are never accepted in RESP, including the handshake cycle.
- rf_sel and rf_wdata keep their last values in IDLE. rf_wr is 1 only in WRITE.
- Addresses 0..31 are all ordinary registers; no address is special-cased.

## Timing
- Reset values: req_ready=0 while reset is high, then 1. rsp_valid=0, rsp_rdata=0, rsp_err=0, rf_sel=0, rf_wr=0, rf_wdata=0, busy=0, txn_count=0, state=IDLE.
- Latency is counted from the accepting edge E0 to the first rsp_valid=1 cycle edge:
  - read: RD_WAIT
  - write: WR_HOLD
  - write, verify build: WR_HOLD+RD_WAIT
- rf_* outputs are registered and change only on posedge clk. They are stable across the negedge in between, which is when the register file samples them.
- Back-to-back throughput: one transaction per latency+2 cycles when rsp_ready is held high.
- Reset asserted in any state: on the next edge, go to IDLE with all outputs at reset values. An in-flight write is dropped, with rf_wr deasserted immediately. No response is produced.
- rsp_ready high while rsp_valid is low is ignored.

## Configuration
- REGFILE_MASTER_VERIFY_EN defined:
  - every write is followed by the VERIFY read-back of the same address.
  - rsp_rdata carries the read-back value.
  - rsp_err flags a mismatch.
- Undefined:
  - VERIFY state, shadow register and comparator are absent.
  - A write response has rsp_rdata=0.
  - rsp_err is tied to 0.

## Test plan
- Write 0xDEADBEEF to addr 5, then read addr 5 -> first response at E0+2, second response rsp_rdata=0xDEADBEEF. With verify enabled the write response has rsp_err=0 and rsp_rdata=0xDEADBEEF.
- Write 0x00000001 to addr 0 and 0xFFFFFFFF to addr 31, then read both -> exactly those values; other addresses still read 0 after reset.
- Read response with rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and busy stay stable, req_ready=0. After the handshake, req_ready=1 one cycle later and txn_count increments by 1.
- Reset asserted one cycle into a write to addr 7 with 0x12345678 -> next cycle rf_wr=0, rsp_valid=0, state IDLE. A subsequent read of addr 3 completes normally.
- Verify build, with a bench model that forces rf_rdata=0xDEADBEEE during VERIFY of a 0xDEADBEEF write -> rsp_err=1, rsp_rdata=0xDEADBEEE.
- txn_count preloaded by running 65535 transactions, then one more -> count wraps to 0.

Source files
------------

// File: rtl/regfile_master.sv
// Request/response sequencer for the single-port 32 x 32 register file.
// Define REGFILE_MASTER_VERIFY_EN to read back and compare every write.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// WRITE  | rf_wr asserted, holding sel/wdata for WR_HOLD edges
// READ   | rf_sel held for RD_WAIT edges, then rf_rdata captured
// VERIFY | read-back of the written address (verify build only)
// RESP   | rsp_valid high until the consumer accepts
module regfile_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int WR_HOLD = 2,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rf_sel,
    output logic              rf_wr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic [15:0]       txn_count
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, VERIFY, RESP} state_t;

    // Hold counters are loaded with N-1 so that the exit happens on the N-th edge.
    localparam logic [7:0] WR_CNT = 8'(WR_HOLD - 1);
    localparam logic [7:0] RD_CNT = 8'(RD_WAIT - 1);

    state_t     state;
    logic [7:0] cnt;

`ifdef REGFILE_MASTER_VERIFY_EN
    logic [DATA_W-1:0] shadow;
    logic              rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rf_sel    <= '0;
            rf_wr     <= 1'b0;
            rf_wdata  <= '0;
            txn_count <= '0;
`ifdef REGFILE_MASTER_VERIFY_EN
            shadow    <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rf_sel   <= req_addr;
                        rf_wdata <= req_wdata;
`ifdef REGFILE_MASTER_VERIFY_EN
                        shadow   <= req_wdata;
`endif
                        rf_wr    <= req_wr;
                        cnt      <= req_wr ? WR_CNT : RD_CNT;
                        state    <= req_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (cnt == 8'd0) begin
                        rf_wr <= 1'b0;
`ifdef REGFILE_MASTER_VERIFY_EN
                        cnt   <= RD_CNT;
                        state <= VERIFY;
`else
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                READ: begin
                    if (cnt == 8'd0) begin
                        rsp_rdata <= rf_rdata;
`ifdef REGFILE_MASTER_VERIFY_EN
                        rsp_err_q <= 1'b0;
`endif
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef REGFILE_MASTER_VERIFY_EN
                VERIFY: begin
                    if (cnt == 8'd0) begin
                        rsp_rdata <= rf_rdata;
                        rsp_err_q <= (rf_rdata != shadow);
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rf_wr     <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_master.sv
// Directed plus random bench for regfile_master with a negedge-sampling
// register-file model and a plain-array reference of expected contents.
module tb_regfile_master;
    localparam int WR_HOLD = 2;
    localparam int RD_WAIT = 2;
`ifdef REGFILE_MASTER_VERIFY_EN
    localparam bit VER    = 1'b1;
    localparam int WR_LAT = WR_HOLD + RD_WAIT;
`else
    localparam bit VER    = 1'b0;
    localparam int WR_LAT = WR_HOLD;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rf_sel;
    logic        rf_wr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        busy;
    logic [15:0] txn_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_count;
    logic [31:0] ref_mem [32];
    logic [31:0] mem [32];
    bit          corrupt = 1'b0;

    always #5 clk = ~clk;

    regfile_master #(.DATA_W(32), .ADDR_W(5), .WR_HOLD(WR_HOLD), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rf_sel(rf_sel), .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .busy(busy), .txn_count(txn_count)
    );

    // Register file: samples the port on the falling edge; corrupt flips bit 0 on reads.
    always @(negedge clk) begin
        if (rf_wr) mem[rf_sel] = rf_wdata;
        rf_rdata <= (corrupt && !rf_wr) ? (mem[rf_sel] ^ 32'h1) : mem[rf_sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                          input int hold, input bit bad_rb);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        int          exp_lat;
        exp_lat = wr ? WR_LAT : RD_WAIT;
        if (wr) begin
            ref_mem[addr] = data;
            exp_rd  = VER ? (bad_rb ? (data ^ 32'h1) : data) : 32'h0;
            exp_err = VER && bad_rb;
        end else begin
            exp_rd  = ref_mem[addr];
            exp_err = 1'b0;
        end
        check("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; corrupt = bad_rb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            check("rf_wr_window", 32'(rf_wr), 32'(wr && (lat < WR_HOLD)));
            check("rf_sel", 32'(rf_sel), 32'(addr));
            check("busy_inflight", 32'(busy), 32'h1);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("req_ready_resp", 32'(req_ready), 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_busy", 32'(busy), 32'h1);
            check("hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        corrupt = 1'b0;
        exp_count = exp_count + 16'd1;
        check("rsp_valid_after", 32'(rsp_valid), 32'h0);
        check("req_ready_after", 32'(req_ready), 32'h1);
        check("txn_count", 32'(txn_count), 32'(exp_count));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        exp_count = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rf_sel", 32'(rf_sel), 32'h0);
        check("rst_rf_wr", 32'(rf_wr), 32'h0);
        check("rst_rf_wdata", rf_wdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_txn_count", 32'(txn_count), 32'h0);
        reset = 1'b0;
        #1;
        check("req_ready_post_rst", 32'(req_ready), 32'h1);

        do_txn(1'b1, 5'd5, 32'hDEADBEEF, 0, 1'b0);
        do_txn(1'b0, 5'd5, 32'h0, 0, 1'b0);
        do_txn(1'b1, 5'd0, 32'h00000001, 0, 1'b0);
        do_txn(1'b1, 5'd31, 32'hFFFFFFFF, 0, 1'b0);
        do_txn(1'b0, 5'd0, 32'h0, 0, 1'b0);
        do_txn(1'b0, 5'd31, 32'h0, 0, 1'b0);
        do_txn(1'b0, 5'd12, 32'h0, 0, 1'b0);
        do_txn(1'b0, 5'd5, 32'h0, 5, 1'b0);

        // rsp_ready without a pending response must have no effect
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stray_ready_valid", 32'(rsp_valid), 32'h0);
        check("stray_ready_count", 32'(txn_count), 32'(exp_count));

        // reset one cycle into a write
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd7; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_rf_wr", 32'(rf_wr), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_count", 32'(txn_count), 32'h0);
        reset = 1'b0;
        #1;
        exp_count = 16'h0;
        ref_mem[7] = mem[7];
        do_txn(1'b0, 5'd3, 32'h0, 0, 1'b0);

`ifdef REGFILE_MASTER_VERIFY_EN
        do_txn(1'b1, 5'd9, 32'hDEADBEEF, 0, 1'b1);
        do_txn(1'b0, 5'd9, 32'h0, 0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   int'($urandom_range(0, 3)), 1'b0);
        end

        // wrap: start the counter at its maximum value
        @(negedge clk);
        force dut.txn_count = 16'hFFFF;
        @(negedge clk);
        release dut.txn_count;
        #1;
        exp_count = 16'hFFFF;
        check("preload_count", 32'(txn_count), 32'h0000FFFF);
        do_txn(1'b0, 5'd31, 32'h0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
